// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register address range through the async read port and streams each value out on a valid/ready interface
// Ports: clk/rst (async active-high); start/abort control; first_addr/last_addr range, latched on start;
//        rf_raddr/rf_rdata register-file read port; out_valid/out_ready/out_addr/out_data/out_last output beat;
//        busy high from accepted start until back in IDLE; done one-cycle pulse after the final beat is accepted.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] cur, end_addr;
    logic hs;
    assign hs       = out_valid && out_ready;
    assign rf_raddr = cur;
    assign done     = state == DONE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = start ? FETCH : IDLE;
            FETCH: state_n = abort ? IDLE : SEND;
            SEND:  state_n = abort ? IDLE : hs ? (out_last ? DONE : FETCH) : SEND;
            DONE:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            end_addr  <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    cur      <= first_addr;
                    end_addr <= last_addr;
                    busy     <= 1'b1;
                end
                FETCH: if (abort) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end else begin
                    out_data  <= rf_rdata;
                    out_addr  <= cur;
                    out_last  <= cur == end_addr;
                    out_valid <= 1'b1;
                end
                // a handshake coinciding with abort still counts as delivered; abort just ends the dump
                SEND: if (abort) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end else if (hs) begin
                    out_valid <= 1'b0;
                    if (!out_last) cur <= ADDR_W'((32'(cur) + 1) % NUM_REGS);
                end
                DONE: busy <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: scoreboard bench for regfile_dump_reader against a preloaded R[i]=i*3 register file
module tb_regfile_dump_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [4:0]  first_addr = '0, last_addr = '0, rf_raddr, out_addr;
    logic [31:0] rf_rdata, out_data;
    logic        out_valid, out_last, busy, done;
    logic [31:0] rf [32];
    int vec = 0, errs = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t q[$];

    assign rf_rdata = rf[rf_raddr];
    always #5 clk = ~clk;

    regfile_dump_reader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string name);
        vec++;
        if ({out_valid, busy, done, out_last, out_addr, out_data, rf_raddr} !== '0) begin
            errs++;
            $display("FAIL %s: valid=%b busy=%b done=%b last=%b addr=%0d data=%0d raddr=%0d, all must be 0",
                     name, out_valid, busy, done, out_last, out_addr, out_data, rf_raddr);
        end
    endtask

    // stall: cycles out_ready is held low on each beat; poke: spurious start while busy; with_abort: abort alongside start
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int stall, input bit poke, input bit with_abort);
        logic [4:0] a;
        beat_t b;
        int cyc, wait_n;
        bit seen;
        a = f;
        for (int i = 0; i < 32; i++) begin
            b = '{addr: a, data: rf[a], last: a == l};
            q.push_back(b);
            if (a == l) break;
            a++;
        end
        first_addr = f; last_addr = l; start = 1'b1; abort = with_abort; out_ready = 1'b0;
        step();
        start = 1'b0; abort = 1'b0;
        vec++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL start_accept: busy=%b valid=%b, need busy=1 valid=0", busy, out_valid);
        end
        cyc = 1; wait_n = 0; seen = 0;
        while (q.size() > 0 && cyc < 600) begin
            start = poke && cyc == 3;
            if (start) begin first_addr = 5'd20; last_addr = 5'd25; end
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    vec++;
                    if (cyc != 2) begin errs++; $display("FAIL latency: first valid %0d cycles after start, need 2", cyc); end
                end
                b = q[0];
                vec++;
                if (out_addr !== b.addr || out_data !== b.data || out_last !== b.last) begin
                    errs++;
                    $display("FAIL beat: addr=%0d data=%0d last=%b, need addr=%0d data=%0d last=%b",
                             out_addr, out_data, out_last, b.addr, b.data, b.last);
                end
                if (wait_n < stall) begin
                    out_ready = 1'b0;
                    wait_n++;
                end else begin
                    out_ready = 1'b1;
                    wait_n = 0;
                    void'(q.pop_front());
                end
            end else out_ready = 1'b1;
            cyc++;
            step();
        end
        start = 1'b0;
        vec++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL dump_timeout: %0d beats left, need 0", q.size());
            q.delete();
        end
        vec++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL done_pulse: done=%b valid=%b busy=%b, need 1 0 1", done, out_valid, busy);
        end
        out_ready = 1'b0;
        step();
        vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL done_end: done=%b busy=%b, need 0 0", done, busy);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (out_valid) ok = 1;
            else step();
        end
        vec++;
        if (!ok) begin errs++; $display("FAIL wait_valid: out_valid=0 after 10 cycles, need 1"); end
    endtask

    task automatic test_reset();
        #1;
        check_idle_outputs("reset_hold");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check_idle_outputs("reset_release");
    endtask

    task automatic test_full_range();
        run_dump(5'd0, 5'd31, 0, 0, 0);
    endtask

    task automatic test_single();
        run_dump(5'd5, 5'd5, 0, 0, 0);
    endtask

    task automatic test_wrap();
        run_dump(5'd30, 5'd1, 0, 0, 0);
    endtask

    task automatic test_stall();
        run_dump(5'd0, 5'd3, 3, 0, 0);
    endtask

    task automatic test_start_ignored();
        run_dump(5'd3, 5'd6, 2, 1, 0);
    endtask

    task automatic test_start_beats_abort();
        run_dump(5'd12, 5'd12, 0, 0, 1);
    endtask

    task automatic test_abort();
        bit ok;
        first_addr = 5'd7; last_addr = 5'd12; start = 1'b1; out_ready = 1'b0;
        step();
        start = 1'b0;
        wait_valid(ok);
        step();
        vec++;
        if (out_valid !== 1'b1 || out_addr !== 5'd7 || out_data !== 32'd21) begin
            errs++;
            $display("FAIL abort_hold: valid=%b addr=%0d data=%0d, need 1 7 21", out_valid, out_addr, out_data);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vec++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin
            errs++;
            $display("FAIL abort: valid=%b busy=%b done=%b last=%b, need all 0", out_valid, busy, done, out_last);
        end
        step();
        vec++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errs++;
            $display("FAIL abort_nodone: done=%b valid=%b, need 0 0", done, out_valid);
        end
        run_dump(5'd2, 5'd4, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        bit ok;
        first_addr = 5'd9; last_addr = 5'd20; start = 1'b1; out_ready = 1'b0;
        step();
        start = 1'b0;
        wait_valid(ok);
        vec++;
        if (out_addr !== 5'd9 || out_data !== 32'd27) begin
            errs++;
            $display("FAIL pre_reset_beat: addr=%0d data=%0d, need 9 27", out_addr, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        step();
        run_dump(5'd9, 5'd10, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
        test_reset();
        test_full_range();
        test_single();
        test_wrap();
        test_stall();
        test_abort();
        test_async_reset();
        test_start_ignored();
        test_start_beats_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
